dot_prod_peak_search: RTL and testbench
=======================================

Name: dot_prod_peak_search

Overview:
- Downstream consumer of the pipelined complex dot-product stage.
- Accepts the stream of signed (i, q) dot-product results and computes |p|^2 = i^2 + q^2 per sample.
- Tracks the maximum over a frame of LENGTH accepted samples, then emits one (peak magnitude, peak index) result per frame with a valid/ready handshake.
- Forms the peak-detect step of the CAF search, after the correlator dot product.

Parameters:
- I_BITS, 32: width of signed input i.
- Q_BITS, 32: width of signed input q.
- LENGTH, 64: accepted samples per frame; must be >= 2.
- INDEX_BITS, $clog2(LENGTH): width of peak_index.
- MAG_BITS, 2*max(I_BITS,Q_BITS): width of the unsigned magnitude-squared. Holds the worst case of i = q = most-negative value.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- m_axis_product_tvalid  in  1  upstream product valid.
- m_axis_product_tready  out  1  ready back to the dot-product stage.
- i  in  I_BITS  signed in-phase product.
- q  in  Q_BITS  signed quadrature product.
- s_axis_peak_tvalid  out  1  frame result valid.
- s_axis_peak_tready  in  1  downstream ready for the result.
- peak_mag  out  MAG_BITS  unsigned maximum |p|^2 of the frame.
- peak_index  out  INDEX_BITS  0-based sample index of peak_mag within the frame.

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high.
- Reset values (all outputs): m_axis_product_tready=0, s_axis_peak_tvalid=0, peak_mag=0, peak_index=0. Internal count, max register and pipeline valids are cleared. tready rises on the first cycle after rst deasserts.
- Accept rule: a sample is accepted on a clk edge where m_axis_product_tvalid && m_axis_product_tready.
- tready is combinational from state only: tready = (state==SEARCH) && (count < LENGTH). It never depends on tvalid.
- Pipeline:
  - S1 registers i*i and q*q, signed multiply, result taken unsigned.
  - S2 registers their sum plus the sample index.
  - S3 compares against the running max; it updates when sum > max (strict).
  - Ties keep the earliest index.
  - The first sample of a frame always loads, regardless of the max value.
- States:
  - SEARCH: accept samples; count increments per accept. On the accept that makes count==LENGTH, go to DRAIN.
  - DRAIN: tready=0; wait until the S1/S2/S3 valids are empty, i.e. the last sample has updated the max. Then latch peak_mag/peak_index and go to OUTPUT.
  - OUTPUT: s_axis_peak_tvalid=1. peak_mag/peak_index are stable while tvalid && !tready. On s_axis_peak_tready, next cycle: tvalid=0, count=0, first-sample flag set, state=SEARCH.
- Latency: last sample accepted at edge t gives s_axis_peak_tvalid high after edge t+4 (3 pipeline stages + latch). If s_axis_peak_tready is already high, tready returns high after edge t+5.
- Gaps: tvalid low mid-frame stalls count and inserts bubbles; bubbles never update the max and do not advance the index.
- Boundaries:
  - All-zero frame gives peak_mag=0, peak_index=0.
  - i=q=-2^(B-1) gives 2^(2B-1) exactly, no overflow.
  - Input presented in DRAIN/OUTPUT is not accepted; upstream must hold it.
  - Outputs may be held indefinitely in OUTPUT.
- Reset mid-frame or mid-OUTPUT: the partial frame is discarded and the block returns to reset values; there is no output for the aborted frame.

Decomposition:
- Shared package holds:
  - the state enumeration (SEARCH, DRAIN, OUTPUT);
  - a function computing MAG_BITS from I_BITS/Q_BITS;
  - the clog2-based INDEX_BITS helper used by other CAF blocks.
- One sub-module: mag_sq_pip. Two-stage registered i^2+q^2 with a valid and an index sideband, reusable by other CAF stages.
- The compare/FSM stays in the top.

Test Plan (LENGTH=8, I_BITS=Q_BITS=8):
1. Continuous valid, samples (i,q) = (1,0),(2,0),(3,4),(0,1),(-5,0),(2,2),(0,0),(1,1) -> peak_mag=25, peak_index=2. s_axis_peak_tvalid rises 4 edges after the 8th accept; tready low from the edge after the 8th accept.
2. Tie: (3,4) at index 1 and (-4,-3) at index 6, all others 0 -> peak_mag=25, peak_index=1.
3. Extremes: (-128,-128) at index 7, others (127,127) -> peak_mag=32768, peak_index=7, no wrap.
4. Backpressure: s_axis_peak_tready low for 10 cycles -> tvalid and outputs stable. tready stays 0 and no inputs are accepted. Release -> next frame starts the cycle after the handshake with count=0.
5. Bubbles: tvalid toggled every other cycle over one frame -> same result as scenario 1. Exactly 8 accepts are counted.
6. rst asserted after the 5th accept of a frame -> all outputs at reset values. The following full frame of scenario 1 data yields peak_index=2 with no stale maximum.

Source files
------------

// File: rtl/dot_prod_peak_search_pkg.sv
// rtl/dot_prod_peak_search_pkg.sv - shared types and width helpers for the CAF peak-search path
package dot_prod_peak_search_pkg;

  typedef enum logic [1:0] {
    SEARCH,
    DRAIN,
    OUTPUT
  } state_t;

  // Width of i^2 + q^2: the worst case i = q = most-negative gives 2^(2B-1).
  function automatic int mag_bits(input int i_bits, input int q_bits);
    return 2 * ((i_bits > q_bits) ? i_bits : q_bits);
  endfunction

  function automatic int index_bits(input int length);
    return (length > 1) ? $clog2(length) : 1;
  endfunction

endpackage

// File: rtl/dot_prod_peak_search_if.sv
// rtl/dot_prod_peak_search_if.sv - product input stream and peak result stream
interface dot_prod_peak_search_if
  import dot_prod_peak_search_pkg::*;
#(
  parameter int I_BITS     = 32,
  parameter int Q_BITS     = 32,
  parameter int MAG_BITS   = mag_bits(I_BITS, Q_BITS),
  parameter int INDEX_BITS = index_bits(64)
);
  logic                    m_axis_product_tvalid;
  logic                    m_axis_product_tready;
  logic signed [I_BITS-1:0] i;
  logic signed [Q_BITS-1:0] q;
  logic                    s_axis_peak_tvalid;
  logic                    s_axis_peak_tready;
  logic [MAG_BITS-1:0]     peak_mag;
  logic [INDEX_BITS-1:0]   peak_index;

  modport master (
    output m_axis_product_tvalid, i, q, s_axis_peak_tready,
    input  m_axis_product_tready, s_axis_peak_tvalid, peak_mag, peak_index
  );

  modport slave (
    input  m_axis_product_tvalid, i, q, s_axis_peak_tready,
    output m_axis_product_tready, s_axis_peak_tvalid, peak_mag, peak_index
  );
endinterface

// File: rtl/dot_prod_peak_search_mag_sq_pip.sv
// rtl/dot_prod_peak_search_mag_sq_pip.sv - two-stage registered i^2 + q^2 with valid and index sideband
module mag_sq_pip #(
  parameter int I_BITS     = 32,
  parameter int Q_BITS     = 32,
  parameter int MAG_BITS   = 64,
  parameter int INDEX_BITS = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic signed [I_BITS-1:0] i,
  input  logic signed [Q_BITS-1:0] q,
  input  logic [INDEX_BITS-1:0] in_index,
  output logic                  out_valid,
  output logic [MAG_BITS-1:0]   out_mag,
  output logic [INDEX_BITS-1:0] out_index,
  output logic                  busy
);
  logic signed [2*I_BITS-1:0] i_ext, ii_full;
  logic signed [2*Q_BITS-1:0] q_ext, qq_full;
  logic [MAG_BITS-1:0]        s1_ii, s1_qq;
  logic [INDEX_BITS-1:0]      s1_index;
  logic                       s1_valid;

  // Sign-extend before multiplying so the full-width square is exact.
  assign i_ext   = (2*I_BITS)'(i);
  assign q_ext   = (2*Q_BITS)'(q);
  assign ii_full = i_ext * i_ext;
  assign qq_full = q_ext * q_ext;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_ii     <= '0;
      s1_qq     <= '0;
      s1_index  <= '0;
      out_valid <= 1'b0;
      out_mag   <= '0;
      out_index <= '0;
    end else begin
      s1_valid  <= in_valid;
      s1_ii     <= MAG_BITS'($unsigned(ii_full));
      s1_qq     <= MAG_BITS'($unsigned(qq_full));
      s1_index  <= in_index;
      out_valid <= s1_valid;
      out_mag   <= s1_ii + s1_qq;
      out_index <= s1_index;
    end
  end

  assign busy = s1_valid || out_valid;
endmodule

// File: rtl/dot_prod_peak_search.sv
// rtl/dot_prod_peak_search.sv - frame peak search over |p|^2 of the dot-product stream
module dot_prod_peak_search
  import dot_prod_peak_search_pkg::*;
#(
  parameter int I_BITS     = 32,
  parameter int Q_BITS     = 32,
  parameter int LENGTH     = 64,
  parameter int INDEX_BITS = index_bits(LENGTH),
  parameter int MAG_BITS   = mag_bits(I_BITS, Q_BITS)
) (
  input logic                   clk,
  input logic                   rst,
  dot_prod_peak_search_if.slave bus
);
  localparam int CNT_BITS = $clog2(LENGTH + 1);

  state_t                state, state_nxt;
  logic                  active;
  logic [CNT_BITS-1:0]   count;
  logic                  accept, handshake, pipe_empty;
  logic                  pip_valid, pip_busy, s3_valid, first;
  logic [MAG_BITS-1:0]   pip_mag, max_mag, peak_mag_q;
  logic [INDEX_BITS-1:0] pip_index, max_index, peak_index_q;

  assign bus.m_axis_product_tready = active && (state == SEARCH) && (count < CNT_BITS'(LENGTH));
  assign bus.s_axis_peak_tvalid    = (state == OUTPUT);
  assign bus.peak_mag              = peak_mag_q;
  assign bus.peak_index            = peak_index_q;

  assign accept     = bus.m_axis_product_tvalid && bus.m_axis_product_tready;
  assign handshake  = (state == OUTPUT) && bus.s_axis_peak_tready;
  assign pipe_empty = !pip_busy && !s3_valid;

  mag_sq_pip #(
    .I_BITS    (I_BITS),
    .Q_BITS    (Q_BITS),
    .MAG_BITS  (MAG_BITS),
    .INDEX_BITS(INDEX_BITS)
  ) u_mag_sq_pip (
    .clk      (clk),
    .rst      (rst),
    .in_valid (accept),
    .i        (bus.i),
    .q        (bus.q),
    .in_index (INDEX_BITS'(count)),
    .out_valid(pip_valid),
    .out_mag  (pip_mag),
    .out_index(pip_index),
    .busy     (pip_busy)
  );

  // Strict compare keeps the earliest index on ties; the first sample always loads.
  always_ff @(posedge clk) begin
    if (rst) begin
      s3_valid  <= 1'b0;
      first     <= 1'b1;
      max_mag   <= '0;
      max_index <= '0;
    end else begin
      s3_valid <= pip_valid;
      if (pip_valid && (first || (pip_mag > max_mag))) begin
        max_mag   <= pip_mag;
        max_index <= pip_index;
      end
      if (pip_valid) first <= 1'b0;
      if (handshake) first <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= SEARCH;
      active       <= 1'b0;
      count        <= '0;
      peak_mag_q   <= '0;
      peak_index_q <= '0;
    end else begin
      state  <= state_nxt;
      active <= 1'b1;
      if (accept) count <= count + CNT_BITS'(1);
      if (handshake) count <= '0;
      if ((state == DRAIN) && pipe_empty) begin
        peak_mag_q   <= max_mag;
        peak_index_q <= max_index;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      SEARCH: if (accept && (count == CNT_BITS'(LENGTH - 1))) state_nxt = DRAIN;
      DRAIN:  if (pipe_empty) state_nxt = OUTPUT;
      OUTPUT: if (bus.s_axis_peak_tready) state_nxt = SEARCH;
      default: state_nxt = SEARCH;
    endcase
  end
endmodule

// File: tb/tb_dot_prod_peak_search.sv
// tb/tb_dot_prod_peak_search.sv - scoreboard bench for dot_prod_peak_search
module tb_dot_prod_peak_search;
  import dot_prod_peak_search_pkg::*;

  localparam int LEN = 8;
  localparam int IB  = 8;
  localparam int QB  = 8;
  localparam int MB  = mag_bits(IB, QB);
  localparam int XB  = index_bits(LEN);

  typedef struct packed {
    logic [MB-1:0] mag;
    logic [XB-1:0] idx;
  } res_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dot_prod_peak_search_if #(.I_BITS(IB), .Q_BITS(QB), .MAG_BITS(MB), .INDEX_BITS(XB)) bus ();

  dot_prod_peak_search #(
    .I_BITS(IB), .Q_BITS(QB), .LENGTH(LEN), .INDEX_BITS(XB), .MAG_BITS(MB)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  res_t sb[$];
  int checks = 0, failures = 0;
  int cyc = 0, accepts = 0, last_acc = 0;

  int s1_i[LEN]  = '{1, 2, 3, 0, -5, 2, 0, 1};
  int s1_q[LEN]  = '{0, 0, 4, 1, 0, 2, 0, 1};
  int tie_i[LEN] = '{0, 3, 0, 0, 0, 0, -4, 0};
  int tie_q[LEN] = '{0, 4, 0, 0, 0, 0, -3, 0};
  int ext_i[LEN] = '{127, 127, 127, 127, 127, 127, 127, -128};
  int ext_q[LEN] = '{127, 127, 127, 127, 127, 127, 127, -128};
  int zero_v[LEN] = '{0, 0, 0, 0, 0, 0, 0, 0};
  int big_v[LEN]  = '{100, 100, 100, 100, 100, 100, 100, 100};

  always @(posedge clk) begin
    cyc++;
    if (bus.m_axis_product_tvalid && bus.m_axis_product_tready) begin
      accepts++;
      last_acc = cyc;
    end
  end

  task automatic chk(input string tag, input longint got, input longint exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic send(input int si, input int sq);
    int n = 0;
    bus.m_axis_product_tvalid = 1'b1;
    bus.i = IB'(si);
    bus.q = QB'(sq);
    while (!bus.m_axis_product_tready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("accept_timeout", n, 0);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive_frame(input int si[LEN], input int sq[LEN], input bit gap, input int nsamp);
    res_t e;
    int best = 0, bidx = 0, m;
    for (int k = 0; k < LEN; k++) begin
      m = si[k] * si[k] + sq[k] * sq[k];
      if (k == 0 || m > best) begin
        best = m;
        bidx = k;
      end
    end
    e.mag = MB'(best);
    e.idx = XB'(bidx);
    if (nsamp == LEN) sb.push_back(e);
    for (int k = 0; k < nsamp; k++) begin
      if (gap && k > 0) begin
        bus.m_axis_product_tvalid = 1'b0;
        @(negedge clk);
      end
      send(si[k], sq[k]);
    end
  endtask

  task automatic collect(input string tag, input int hold);
    res_t e;
    int n = 0;
    int a0;
    logic [MB-1:0] m0;
    logic [XB-1:0] x0;
    while (!bus.s_axis_peak_tvalid && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      chk({tag, "_timeout"}, n, 0);
      return;
    end
    chk({tag, "_latency"}, cyc - last_acc, 4);
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 0, 1);
      return;
    end
    e = sb.pop_front();
    chk({tag, "_mag"}, bus.peak_mag, e.mag);
    chk({tag, "_idx"}, bus.peak_index, e.idx);
    if (hold > 0) begin
      m0 = bus.peak_mag;
      x0 = bus.peak_index;
      a0 = accepts;
      bus.m_axis_product_tvalid = 1'b1;
      bus.i = 8'sd7;
      bus.q = 8'sd7;
      for (int h = 0; h < hold; h++) begin
        @(negedge clk);
        chk({tag, "_hold_tvalid"}, bus.s_axis_peak_tvalid, 1);
        chk({tag, "_hold_tready"}, bus.m_axis_product_tready, 0);
        chk({tag, "_hold_mag"}, bus.peak_mag, m0);
        chk({tag, "_hold_idx"}, bus.peak_index, x0);
      end
      chk({tag, "_hold_no_accept"}, accepts - a0, 0);
      bus.m_axis_product_tvalid = 1'b0;
    end
    bus.s_axis_peak_tready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.s_axis_peak_tready = 1'b0;
    chk({tag, "_post_tvalid"}, bus.s_axis_peak_tvalid, 0);
    chk({tag, "_post_tready"}, bus.m_axis_product_tready, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int a0;
    rst = 1'b1;
    bus.m_axis_product_tvalid = 1'b0;
    bus.s_axis_peak_tready = 1'b0;
    bus.i = '0;
    bus.q = '0;
    repeat (3) @(negedge clk);
    chk("rst_tready", bus.m_axis_product_tready, 0);
    chk("rst_tvalid", bus.s_axis_peak_tvalid, 0);
    chk("rst_mag", bus.peak_mag, 0);
    chk("rst_idx", bus.peak_index, 0);
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_release_tready", bus.m_axis_product_tready, 1);

    // Continuous frame with downstream already ready
    bus.s_axis_peak_tready = 1'b1;
    drive_frame(s1_i, s1_q, 1'b0, LEN);
    chk("t1_tready_drop", bus.m_axis_product_tready, 0);
    bus.m_axis_product_tvalid = 1'b0;
    collect("t1", 0);

    drive_frame(tie_i, tie_q, 1'b0, LEN);
    bus.m_axis_product_tvalid = 1'b0;
    collect("t2_tie", 0);

    drive_frame(ext_i, ext_q, 1'b0, LEN);
    bus.m_axis_product_tvalid = 1'b0;
    collect("t3_ext", 0);

    drive_frame(zero_v, zero_v, 1'b0, LEN);
    bus.m_axis_product_tvalid = 1'b0;
    collect("t_zero", 0);

    drive_frame(tie_i, tie_q, 1'b0, LEN);
    bus.m_axis_product_tvalid = 1'b0;
    collect("t4_bp", 10);

    a0 = accepts;
    drive_frame(s1_i, s1_q, 1'b1, LEN);
    bus.m_axis_product_tvalid = 1'b0;
    chk("t5_accepts", accepts - a0, LEN);
    collect("t5_bubble", 0);

    // Abort a frame of large samples after 5 accepts
    drive_frame(big_v, big_v, 1'b0, 5);
    bus.m_axis_product_tvalid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("t6_rst_tready", bus.m_axis_product_tready, 0);
    chk("t6_rst_tvalid", bus.s_axis_peak_tvalid, 0);
    chk("t6_rst_mag", bus.peak_mag, 0);
    chk("t6_rst_idx", bus.peak_index, 0);
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    drive_frame(s1_i, s1_q, 1'b0, LEN);
    bus.m_axis_product_tvalid = 1'b0;
    collect("t6_after", 0);
    chk("sb_drained", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
